// File: rtl/icb_sram_slave.sv
// icb_sram_slave: ICB target terminating onto a single-port SRAM with a 1-cycle
// read latency. Provides an address range check, a 2-entry response queue for
// backpressure, and a single-entry exclusive-access reservation monitor.
module icb_sram_slave #(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            USR_W     = 1,
  parameter int            RAM_AW    = 12,
  parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              icb_slave_active,
  input  logic              i_icb_cmd_valid,
  output logic              i_icb_cmd_ready,
  input  logic              i_icb_cmd_read,
  input  logic [AW-1:0]     i_icb_cmd_addr,
  input  logic [DW-1:0]     i_icb_cmd_wdata,
  input  logic [DW/8-1:0]   i_icb_cmd_wmask,
  input  logic              i_icb_cmd_lock,
  input  logic              i_icb_cmd_excl,
  input  logic [1:0]        i_icb_cmd_size,
  input  logic [1:0]        i_icb_cmd_burst,
  input  logic [1:0]        i_icb_cmd_beat,
  input  logic [USR_W-1:0]  i_icb_cmd_usr,
  output logic              i_icb_rsp_valid,
  input  logic              i_icb_rsp_ready,
  output logic              i_icb_rsp_err,
  output logic              i_icb_rsp_excl_ok,
  output logic [DW-1:0]     i_icb_rsp_rdata,
  output logic [USR_W-1:0]  i_icb_rsp_usr,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW/8-1:0]   ram_wem,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout
);

  localparam int MW     = DW / 8;
  localparam int BW     = $clog2(MW);
  localparam int TAG_LO = RAM_AW + BW;

  typedef struct packed {
    logic             err;
    logic             excl_ok;
    logic [DW-1:0]    rdata;
    logic [USR_W-1:0] usr;
  } rsp_t;

  // Outstanding count, pipe stage, reservation and queue state
  logic [1:0]        cnt_q, cnt_d;
  logic              pipe_vld_q, pipe_vld_d;
  logic              pipe_rd_q, pipe_rd_d;
  logic              pipe_err_q, pipe_err_d;
  logic              pipe_excl_ok_q, pipe_excl_ok_d;
  logic [USR_W-1:0]  pipe_usr_q, pipe_usr_d;
  logic              resv_vld_q, resv_vld_d;
  logic [RAM_AW-1:0] resv_addr_q, resv_addr_d;
  logic [1:0]        q_cnt_q, q_cnt_d;
  logic              q_wr_q, q_wr_d;
  logic              q_rd_q, q_rd_d;
  rsp_t              q_mem_q [2];
  rsp_t              q_mem_d [2];

  logic              cmd_hsk_s;
  logic              rsp_hsk_s;
  logic              in_range_s;
  logic [RAM_AW-1:0] word_s;
  logic              resv_hit_s;
  logic              excl_wr_fail_s;
  logic              access_s;
  logic              cmd_excl_ok_s;
  logic              q_empty_s;
  logic              q_push_s;
  logic              q_pop_s;
  rsp_t              pipe_rsp_s;
  rsp_t              rsp_cur_s;
  logic              unused_s;

  // Fields that carry no meaning for a single-beat word-wide SRAM target
  assign unused_s = ^{i_icb_cmd_lock, i_icb_cmd_size, i_icb_cmd_burst,
                      i_icb_cmd_beat, i_icb_cmd_addr[BW-1:0]};

  // Ready depends on registered state only so rsp_ready never reaches cmd_ready
  assign i_icb_cmd_ready  = (cnt_q != 2'd2);
  assign cmd_hsk_s        = i_icb_cmd_valid & i_icb_cmd_ready;
  assign rsp_hsk_s        = i_icb_rsp_valid & i_icb_rsp_ready;
  assign icb_slave_active = i_icb_cmd_valid | (cnt_q != 2'd0);

  assign in_range_s     = (i_icb_cmd_addr[AW-1:TAG_LO] == BASE_ADDR[AW-1:TAG_LO]);
  assign word_s         = i_icb_cmd_addr[TAG_LO-1:BW];
  assign resv_hit_s     = resv_vld_q & (resv_addr_q == word_s);
  // A failed exclusive store must not reach the array
  assign excl_wr_fail_s = i_icb_cmd_excl & ~i_icb_cmd_read & ~resv_hit_s;
  assign access_s       = cmd_hsk_s & in_range_s & ~excl_wr_fail_s;
  assign cmd_excl_ok_s  = in_range_s & i_icb_cmd_excl & (i_icb_cmd_read | resv_hit_s);

  assign ram_cs   = access_s;
  assign ram_we   = access_s & ~i_icb_cmd_read;
  assign ram_wem  = ram_we ? i_icb_cmd_wmask : {MW{1'b0}};
  assign ram_din  = i_icb_cmd_wdata;
  assign ram_addr = word_s;

  // Response as seen from the pipe stage; read data arrives from the SRAM now
  assign pipe_rsp_s.err     = pipe_err_q;
  assign pipe_rsp_s.excl_ok = pipe_excl_ok_q;
  assign pipe_rsp_s.rdata   = pipe_rd_q ? ram_dout : {DW{1'b0}};
  assign pipe_rsp_s.usr     = pipe_usr_q;

  // Queue head has priority so ordering is preserved behind older responses
  assign q_empty_s = (q_cnt_q == 2'd0);
  assign rsp_cur_s = q_empty_s ? pipe_rsp_s : q_mem_q[q_rd_q];
  assign q_pop_s   = ~q_empty_s & i_icb_rsp_ready;
  assign q_push_s  = pipe_vld_q & (~q_empty_s | ~i_icb_rsp_ready);

  assign i_icb_rsp_valid   = ~q_empty_s | pipe_vld_q;
  assign i_icb_rsp_err     = rsp_cur_s.err;
  assign i_icb_rsp_excl_ok = rsp_cur_s.excl_ok;
  assign i_icb_rsp_rdata   = rsp_cur_s.rdata;
  assign i_icb_rsp_usr     = rsp_cur_s.usr;

  // Outstanding transaction count: up on accept, down on response taken
  always_comb begin
    cnt_d = cnt_q;
    case ({cmd_hsk_s, rsp_hsk_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pipe stage captures the response attributes of the accepted command
  always_comb begin
    pipe_vld_d     = cmd_hsk_s;
    pipe_rd_d      = cmd_hsk_s & i_icb_cmd_read & in_range_s;
    pipe_err_d     = ~in_range_s;
    pipe_excl_ok_d = cmd_excl_ok_s;
    pipe_usr_d     = i_icb_cmd_usr;
  end

  // Exclusive monitor: excl read reserves, any store to the reserved word or any excl store releases
  always_comb begin
    resv_vld_d  = resv_vld_q;
    resv_addr_d = resv_addr_q;
    if (cmd_hsk_s & in_range_s) begin
      if (i_icb_cmd_excl & i_icb_cmd_read) begin
        resv_vld_d  = 1'b1;
        resv_addr_d = word_s;
      end else if (i_icb_cmd_excl) begin
        resv_vld_d  = 1'b0;
      end else if (~i_icb_cmd_read & resv_hit_s) begin
        resv_vld_d  = 1'b0;
      end else begin
        resv_vld_d  = resv_vld_q;
      end
    end else begin
      resv_vld_d = resv_vld_q;
    end
  end

  // Response queue bookkeeping: push untaken pipe entries, pop on acceptance
  always_comb begin
    q_mem_d = q_mem_q;
    q_wr_d  = q_wr_q;
    q_rd_d  = q_rd_q;
    q_cnt_d = q_cnt_q;
    if (q_push_s) begin
      q_mem_d[q_wr_q] = pipe_rsp_s;
      q_wr_d          = ~q_wr_q;
    end else begin
      q_wr_d = q_wr_q;
    end
    if (q_pop_s) begin
      q_rd_d = ~q_rd_q;
    end else begin
      q_rd_d = q_rd_q;
    end
    case ({q_push_s, q_pop_s})
      2'b10:   q_cnt_d = q_cnt_q + 2'd1;
      2'b01:   q_cnt_d = q_cnt_q - 2'd1;
      default: q_cnt_d = q_cnt_q;
    endcase
  end

  // Control state with synchronous reset; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 2'd0;
      pipe_vld_q  <= 1'b0;
      resv_vld_q  <= 1'b0;
      resv_addr_q <= {RAM_AW{1'b0}};
      q_cnt_q     <= 2'd0;
      q_wr_q      <= 1'b0;
      q_rd_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      resv_vld_q  <= resv_vld_d;
      resv_addr_q <= resv_addr_d;
      q_cnt_q     <= q_cnt_d;
      q_wr_q      <= q_wr_d;
      q_rd_q      <= q_rd_d;
    end
  end

  // Datapath payload registers, qualified by the valid/count state above
  always_ff @(posedge clk) begin
    pipe_rd_q      <= pipe_rd_d;
    pipe_err_q     <= pipe_err_d;
    pipe_excl_ok_q <= pipe_excl_ok_d;
    pipe_usr_q     <= pipe_usr_d;
    q_mem_q        <= q_mem_d;
  end

  icb_sram_slave_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .q_push (q_push_s),
    .q_pop  (q_pop_s),
    .q_cnt  (q_cnt_q),
    .cnt    (cnt_q)
  );

endmodule

// Protocol checker for icb_sram_slave internal invariants
module icb_sram_slave_chk (
  input logic       clk,
  input logic       rst,
  input logic       q_push,
  input logic       q_pop,
  input logic [1:0] q_cnt,
  input logic [1:0] cnt
);

  a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(q_push && !q_pop && (q_cnt == 2'd2)));

  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    (cnt != 2'd3));

endmodule

// File: tb/tb_icb_sram_slave.sv
// Self-checking bench for icb_sram_slave: behavioural SRAM, word-level reference
// model with an exclusive reservation, and per-scenario tasks.
module tb_icb_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        icb_slave_active;
  logic        i_icb_cmd_valid, i_icb_cmd_ready, i_icb_cmd_read;
  logic [31:0] i_icb_cmd_addr, i_icb_cmd_wdata;
  logic [3:0]  i_icb_cmd_wmask;
  logic        i_icb_cmd_lock, i_icb_cmd_excl;
  logic [1:0]  i_icb_cmd_size, i_icb_cmd_burst, i_icb_cmd_beat;
  logic [0:0]  i_icb_cmd_usr;
  logic        i_icb_rsp_valid, i_icb_rsp_ready, i_icb_rsp_err, i_icb_rsp_excl_ok;
  logic [31:0] i_icb_rsp_rdata;
  logic [0:0]  i_icb_rsp_usr;
  logic        ram_cs, ram_we;
  logic [11:0] ram_addr;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din, ram_dout;

  logic        fill;
  logic [31:0] sram    [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        ref_rv;
  logic [11:0] ref_rw;
  logic [34:0] exp_q[$];   // {err, excl_ok, rdata, usr}
  logic [34:0] obs_q[$];
  logic        acc_s;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  icb_sram_slave dut (
    .clk(clk), .rst(rst), .icb_slave_active(icb_slave_active),
    .i_icb_cmd_valid(i_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
    .i_icb_cmd_read(i_icb_cmd_read), .i_icb_cmd_addr(i_icb_cmd_addr),
    .i_icb_cmd_wdata(i_icb_cmd_wdata), .i_icb_cmd_wmask(i_icb_cmd_wmask),
    .i_icb_cmd_lock(i_icb_cmd_lock), .i_icb_cmd_excl(i_icb_cmd_excl),
    .i_icb_cmd_size(i_icb_cmd_size), .i_icb_cmd_burst(i_icb_cmd_burst),
    .i_icb_cmd_beat(i_icb_cmd_beat), .i_icb_cmd_usr(i_icb_cmd_usr),
    .i_icb_rsp_valid(i_icb_rsp_valid), .i_icb_rsp_ready(i_icb_rsp_ready),
    .i_icb_rsp_err(i_icb_rsp_err), .i_icb_rsp_excl_ok(i_icb_rsp_excl_ok),
    .i_icb_rsp_rdata(i_icb_rsp_rdata), .i_icb_rsp_usr(i_icb_rsp_usr),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Behavioural SRAM with 1-cycle read latency
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 4096; i++) sram[i] <= init_word(i);
    end else if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= sram[ram_addr];
      end
    end
  end

  // One clock: sample at negedge, update the reference model on accept, record responses
  task automatic tick();
    logic [11:0] w;
    logic        inr, ok, hit;
    logic [31:0] rd;
    @(negedge clk);
    acc_s = 1'b0;
    if (!rst && i_icb_cmd_valid && i_icb_cmd_ready) begin
      acc_s = 1'b1;
      w   = i_icb_cmd_addr[13:2];
      inr = (i_icb_cmd_addr[31:14] == 18'h20000);
      ok  = 1'b0;
      rd  = 32'h0;
      if (inr) begin
        if (i_icb_cmd_read) begin
          rd = ref_mem[w];
          if (i_icb_cmd_excl) begin ok = 1'b1; ref_rv = 1'b1; ref_rw = w; end
        end else begin
          hit = ref_rv && (ref_rw == w);
          if (!i_icb_cmd_excl || hit)
            for (int b = 0; b < 4; b++)
              if (i_icb_cmd_wmask[b]) ref_mem[w][8*b +: 8] = i_icb_cmd_wdata[8*b +: 8];
          if (i_icb_cmd_excl) begin ok = hit; ref_rv = 1'b0; end
          else if (hit) ref_rv = 1'b0;
        end
      end
      exp_q.push_back({!inr, ok, rd, i_icb_cmd_usr});
    end
    if (!rst && i_icb_rsp_valid && i_icb_rsp_ready)
      obs_q.push_back({i_icb_rsp_err, i_icb_rsp_excl_ok, i_icb_rsp_rdata, i_icb_rsp_usr});
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic rd, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic ex, input logic u);
    i_icb_cmd_valid = 1'b1; i_icb_cmd_read = rd; i_icb_cmd_addr = a;
    i_icb_cmd_wdata = d; i_icb_cmd_wmask = m; i_icb_cmd_excl = ex; i_icb_cmd_usr = u;
  endtask

  task automatic do_cmd(input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic ex, input logic u);
    int k = 0;
    set_cmd(rd, a, d, m, ex, u);
    acc_s = 1'b0;
    while (!acc_s && k < 20) begin tick(); k++; end
    i_icb_cmd_valid = 1'b0;
    if (!acc_s) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_accept_timeout: accepted=%0b required=1 addr=%h", acc_s, a);
    end
  endtask

  task automatic drain();
    int k = 0;
    i_icb_cmd_valid = 1'b0;
    i_icb_rsp_ready = 1'b1;
    while (obs_q.size() < exp_q.size() && k < 50) begin tick(); k++; end
    tick();
  endtask

  task automatic test_reset();
    n_cmp++; if (i_icb_cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", i_icb_cmd_ready); end
    n_cmp++; if (i_icb_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", i_icb_rsp_valid); end
    n_cmp++; if (ram_cs !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram: cs=%b we=%b want 0 0", ram_cs, ram_we); end
    n_cmp++; if (icb_slave_active !== 1'b0) begin n_err++; $display("FAIL reset_active_idle: got %b want 0", icb_slave_active); end
    set_cmd(1'b1, 32'h9000_0000, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (icb_slave_active !== 1'b1) begin n_err++; $display("FAIL reset_active_valid: got %b want 1", icb_slave_active); end
    i_icb_cmd_valid = 1'b0;
    #1;
  endtask

  task automatic test_write_read();
    logic [34:0] e, o;
    set_cmd(1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 12'd4 || ram_wem !== 4'hF || ram_din !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL wr_ram_port: cs=%b we=%b addr=%h wem=%h din=%h want 1 1 004 f deadbeef", ram_cs, ram_we, ram_addr, ram_wem, ram_din);
    end
    tick();
    set_cmd(1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 12'd4 || ram_wem !== 4'h0) begin
      n_err++; $display("FAIL rd_ram_port: cs=%b we=%b addr=%h wem=%h want 1 0 004 0", ram_cs, ram_we, ram_addr, ram_wem);
    end
    tick();
    i_icb_cmd_valid = 1'b0;
    n_cmp++;
    if (i_icb_rsp_valid !== 1'b1 || i_icb_rsp_rdata !== 32'hDEAD_BEEF || i_icb_rsp_err !== 1'b0) begin
      n_err++; $display("FAIL rd_latency: valid=%b rdata=%h err=%b want 1 deadbeef 0", i_icb_rsp_valid, i_icb_rsp_rdata, i_icb_rsp_err);
    end
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL wr_rd_rsp: got %h want %h", o, e); end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL wr_rd_count: left exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size()); exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_byte_write();
    logic [34:0] e, o;
    logic [31:0] got [3];
    int n = 0;
    do_cmd(1'b0, 32'h8000_0040, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
    do_cmd(1'b0, 32'h8000_0040, 32'h0000_AA00, 4'b0010, 1'b0, 1'b0);
    do_cmd(1'b1, 32'h8000_0040, 32'h0, 4'h0, 1'b0, 1'b0);
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (n < 3) got[n] = o[32:1];
      n++;
      if (o !== e) begin n_err++; $display("FAIL byte_rsp: got %h want %h", o, e); end
    end
    n_cmp++;
    if (n != 3 || exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL byte_count: got %0d want 3", n); exp_q.delete(); obs_q.delete(); end
    else begin
      n_cmp++;
      if (got[2] !== 32'h1122_AA44) begin n_err++; $display("FAIL byte_merge: got %h want 1122aa44", got[2]); end
    end
  endtask

  task automatic test_out_of_range();
    set_cmd(1'b1, 32'h9000_0000, 32'h0, 4'h0, 1'b0, 1'b1);
    #1;
    n_cmp++; if (ram_cs !== 1'b0) begin n_err++; $display("FAIL oor_ram_cs: got %b want 0", ram_cs); end
    tick();
    i_icb_cmd_valid = 1'b0;
    n_cmp++;
    if (i_icb_rsp_valid !== 1'b1 || i_icb_rsp_err !== 1'b1 || i_icb_rsp_rdata !== 32'h0 || i_icb_rsp_usr !== 1'b1 || i_icb_rsp_excl_ok !== 1'b0) begin
      n_err++; $display("FAIL oor_rsp: valid=%b err=%b rdata=%h usr=%b exok=%b want 1 1 0 1 0", i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_rdata, i_icb_rsp_usr, i_icb_rsp_excl_ok);
    end
    drain();
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [34:0] e, o;
    logic [31:0] a [3];
    int idx = 0;
    for (int i = 0; i < 3; i++) a[i] = 32'h8000_0000 | (32'($urandom_range(0, 4095)) << 2);
    i_icb_rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (idx < 3) set_cmd(1'b1, a[idx], 32'h0, 4'h0, 1'b0, idx[0]);
      else i_icb_cmd_valid = 1'b0;
      if (cyc >= 2 && cyc <= 4) begin
        n_cmp++; if (i_icb_cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_cmd_ready cyc%0d: got %b want 0", cyc, i_icb_cmd_ready); end
      end
      if (cyc == 4) begin
        n_cmp++; if (idx != 2) begin n_err++; $display("FAIL bp_accepts: got %0d want 2", idx); end
      end
      if (cyc == 5) i_icb_rsp_ready = 1'b1;
      tick();
      if (acc_s) idx++;
    end
    n_cmp++; if (idx != 3) begin n_err++; $display("FAIL bp_third_accept: got %0d want 3", idx); end
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL bp_rsp: got %h want %h", o, e); end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL bp_count: left exp=%0d obs=%0d", exp_q.size(), obs_q.size()); exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_exclusive();
    logic [34:0] e, o;
    logic [34:0] got [12];
    logic        want_ok [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int n = 0;
    do_cmd(1'b1, 32'h8000_0020, 32'h0,         4'h0, 1'b1, 1'b0);
    do_cmd(1'b0, 32'h8000_0020, 32'hCAFE_0001, 4'hF, 1'b1, 1'b0);
    do_cmd(1'b0, 32'h8000_0020, 32'hCAFE_0002, 4'hF, 1'b1, 1'b0);
    do_cmd(1'b1, 32'h8000_0020, 32'h0,         4'h0, 1'b0, 1'b0);
    do_cmd(1'b1, 32'h8000_0020, 32'h0,         4'h0, 1'b1, 1'b0);
    do_cmd(1'b0, 32'h8000_0020, 32'hCAFE_0003, 4'hF, 1'b0, 1'b0);
    do_cmd(1'b0, 32'h8000_0020, 32'hCAFE_0004, 4'hF, 1'b1, 1'b0);
    do_cmd(1'b1, 32'h8000_0020, 32'h0,         4'h0, 1'b0, 1'b0);
    do_cmd(1'b1, 32'h8000_0020, 32'h0,         4'h0, 1'b1, 1'b0);
    do_cmd(1'b1, 32'h9000_0020, 32'h0,         4'h0, 1'b1, 1'b0);
    do_cmd(1'b0, 32'h8000_0020, 32'hCAFE_0005, 4'hF, 1'b1, 1'b0);
    do_cmd(1'b1, 32'h8000_0020, 32'h0,         4'h0, 1'b0, 1'b0);
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (n < 12) got[n] = o;
      n++;
      if (o !== e) begin n_err++; $display("FAIL excl_rsp: got %h want %h", o, e); end
    end
    n_cmp++;
    if (n != 12 || exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL excl_count: got %0d want 12", n); exp_q.delete(); obs_q.delete(); end
    else begin
      for (int i = 0; i < 12; i++) begin
        n_cmp++;
        if (got[i][33] !== want_ok[i]) begin n_err++; $display("FAIL excl_ok_%0d: got %b want %b", i, got[i][33], want_ok[i]); end
      end
      n_cmp++; if (got[3][32:1]  !== 32'hCAFE_0001) begin n_err++; $display("FAIL excl_data_a: got %h want cafe0001", got[3][32:1]); end
      n_cmp++; if (got[7][32:1]  !== 32'hCAFE_0003) begin n_err++; $display("FAIL excl_data_b: got %h want cafe0003", got[7][32:1]); end
      n_cmp++; if (got[11][32:1] !== 32'hCAFE_0005) begin n_err++; $display("FAIL excl_data_c: got %h want cafe0005", got[11][32:1]); end
      n_cmp++; if (got[9][34] !== 1'b1) begin n_err++; $display("FAIL excl_oor_err: got %b want 1", got[9][34]); end
    end
  endtask

  task automatic test_throughput();
    logic [34:0] e, o;
    int acc = 0;
    i_icb_rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 17; cyc++) begin
      if (cyc < 16) set_cmd(1'b1, 32'h8000_0000 | (32'($urandom_range(0, 4095)) << 2), 32'h0, 4'h0, 1'b0, 1'($urandom));
      else i_icb_cmd_valid = 1'b0;
      n_cmp++; if (i_icb_cmd_ready !== 1'b1) begin n_err++; $display("FAIL tp_cmd_ready cyc%0d: got %b want 1", cyc, i_icb_cmd_ready); end
      tick();
      if (acc_s) acc++;
    end
    n_cmp++; if (acc != 16 || obs_q.size() != 16) begin n_err++; $display("FAIL tp_rate: accepted=%0d responses=%0d want 16 16", acc, obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL tp_rsp: got %h want %h", o, e); end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL tp_count: left exp=%0d obs=%0d", exp_q.size(), obs_q.size()); exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    logic [34:0] e, o;
    i_icb_rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      set_cmd(1'b1, 32'h8000_0100, 32'h0, 4'h0, 1'b1, 1'b0);
      tick();
    end
    n_cmp++; if (i_icb_rsp_valid !== 1'b1 || i_icb_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_pre: valid=%b ready=%b want 1 0", i_icb_rsp_valid, i_icb_cmd_ready); end
    rst = 1'b1; i_icb_cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); obs_q.delete(); ref_rv = 1'b0;
    n_cmp++; if (i_icb_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_rsp_valid: got %b want 0", i_icb_rsp_valid); end
    n_cmp++; if (i_icb_cmd_ready !== 1'b1 || icb_slave_active !== 1'b0) begin n_err++; $display("FAIL rstmid_cnt: ready=%b active=%b want 1 0", i_icb_cmd_ready, icb_slave_active); end
    i_icb_rsp_ready = 1'b1;
    // Reservation taken before reset must be gone
    do_cmd(1'b0, 32'h8000_0100, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
    do_cmd(1'b1, 32'h8000_0100, 32'h0, 4'h0, 1'b0, 1'b1);
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL rstmid_rsp: got %h want %h", o, e); end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL rstmid_count: left exp=%0d obs=%0d", exp_q.size(), obs_q.size()); exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_random();
    logic [34:0] e, o;
    logic [31:0] a;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h9000_0000 | (32'($urandom_range(0, 3)) << 2);
      else a = 32'h8000_0200 | (32'($urandom_range(0, 3)) << 2);
      set_cmd(1'($urandom), a, $urandom, 4'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom));
      i_icb_cmd_valid = ($urandom_range(0, 3) != 0);
      i_icb_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    n_cmp++; if (exp_q.size() < 100) begin n_err++; $display("FAIL rnd_activity: accepted %0d want >=100", exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL rnd_rsp: got %h want %h", o, e); end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL rnd_count: left exp=%0d obs=%0d", exp_q.size(), obs_q.size()); exp_q.delete(); obs_q.delete(); end
  endtask

  initial begin
    rst = 1'b1; fill = 1'b1;
    i_icb_cmd_valid = 1'b0; i_icb_cmd_read = 1'b0; i_icb_cmd_addr = 32'h0;
    i_icb_cmd_wdata = 32'h0; i_icb_cmd_wmask = 4'h0; i_icb_cmd_lock = 1'b0;
    i_icb_cmd_excl = 1'b0; i_icb_cmd_size = 2'd2; i_icb_cmd_burst = 2'd0;
    i_icb_cmd_beat = 2'd0; i_icb_cmd_usr = 1'b0; i_icb_rsp_ready = 1'b1;
    ref_rv = 1'b0; ref_rw = 12'h0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    @(posedge clk); #1;
    fill = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_out_of_range();
    test_backpressure();
    test_exclusive();
    test_throughput();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
